// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: preset BCD down-count timer with pause, clear and auto-restart
module bcd_timer_ctrl #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pause,
   input  logic                clear,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                tick,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [1:0]          state,
   output logic                busy,
   output logic                done
);
   localparam int W = 4 * DIGITS;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3} state_t;
   state_t         state_q;
   logic [W-1:0]   cnt_q, preset_q;
   logic           done_q;
   logic [W-1:0]   load_clamp, cnt_dec;
   logic           borrow;
   // Per-digit clamp of the preset and ripple-borrow BCD decrement of the count
   always_comb begin
      load_clamp = '0;
      cnt_dec    = '0;
      borrow     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         load_clamp[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
         cnt_dec[4*i +: 4]    = borrow ? ((cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1)
                                       : cnt_q[4*i +: 4];
         borrow               = borrow && (cnt_q[4*i +: 4] == 4'd0);
      end
   end
   // Control FSM: priority rst > clear > load > start > pause > tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         preset_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else if (load && state_q != S_RUN) begin
            preset_q <= load_clamp;
            cnt_q    <= load_clamp;
         end else begin
            case (state_q)
               S_IDLE:  if (start && cnt_q != '0) state_q <= S_RUN;
               S_RUN: begin
                  if (pause) state_q <= S_PAUSE;
                  else if (tick) begin
                     cnt_q <= cnt_dec;
                     if (cnt_q == W'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               S_PAUSE: if (start) state_q <= S_RUN;
               default: if (start && preset_q != '0) begin
                  cnt_q   <= preset_q;
                  state_q <= S_RUN;
               end
            endcase
         end
      end
   end
   assign bcd_out = cnt_q;
   assign state   = state_q;
   assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
   assign done    = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed self-checking bench for bcd_timer_ctrl
module tb_bcd_timer_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, pause, clear, load, tick;
   logic [7:0] load_val;
   logic [7:0] bcd_out;
   logic [1:0] state;
   logic       busy, done;
   int         cmp = 0;
   int         bad = 0;

   bcd_timer_ctrl #(.DIGITS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
      .load(load), .load_val(load_val), .tick(tick),
      .bcd_out(bcd_out), .state(state), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic zero();
      {rst, start, pause, clear, load, tick} = '0;
      load_val = 8'h00;
   endtask

   task automatic test_reset();
      zero();
      rst = 1'b1; cyc(); rst = 1'b0;
      cmp++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
      cmp++; if (bcd_out !== 8'h00) begin bad++; $display("FAIL reset_bcd got %h want 00", bcd_out); end
      cmp++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
      cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_countdown();
      logic [7:0] exp_seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                                   8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
      int pulses = 0;
      load_val = 8'h12; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (bcd_out !== 8'h12 || state !== 2'd0) begin bad++; $display("FAIL cd_load got %h/%0d want 12/0", bcd_out, state); end
      start = 1'b1; cyc(); start = 1'b0;
      cmp++; if (state !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL cd_start got %0d/%b want 1/1", state, busy); end
      tick = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (done === 1'b1) pulses++;
         cmp++; if (bcd_out !== exp_seq[k]) begin bad++; $display("FAIL cd_step%0d got %h want %h", k, bcd_out, exp_seq[k]); end
      end
      cmp++; if (done !== 1'b1 || state !== 2'd3) begin bad++; $display("FAIL cd_done got %b/%0d want 1/3", done, state); end
      cyc(); tick = 1'b0;
      if (done === 1'b1) pulses++;
      cmp++; if (pulses != 1) begin bad++; $display("FAIL cd_pulses got %0d want 1", pulses); end
      cmp++; if (state !== 2'd3 || bcd_out !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL cd_hold got %0d/%h want 3/00", state, bcd_out); end
   endtask

   task automatic test_restart();
      start = 1'b1; cyc(); start = 1'b0;
      cmp++; if (bcd_out !== 8'h12 || state !== 2'd1) begin bad++; $display("FAIL rs_auto got %h/%0d want 12/1", bcd_out, state); end
      clear = 1'b1; cyc(); clear = 1'b0;
      cmp++; if (bcd_out !== 8'h00 || state !== 2'd0) begin bad++; $display("FAIL rs_clear got %h/%0d want 00/0", bcd_out, state); end
      start = 1'b1; cyc(); start = 1'b0;
      cmp++; if (state !== 2'd0) begin bad++; $display("FAIL rs_idle_zero got %0d want 0", state); end
      load_val = 8'h01; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; cyc(); tick = 1'b0;
      cmp++; if (state !== 2'd3 || done !== 1'b1) begin bad++; $display("FAIL rs_one got %0d/%b want 3/1", state, done); end
      load_val = 8'h00; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (state !== 2'd3 || done !== 1'b0) begin bad++; $display("FAIL rs_load_done got %0d/%b want 3/0", state, done); end
      start = 1'b1; cyc(); start = 1'b0;
      cmp++; if (state !== 2'd3 || bcd_out !== 8'h00) begin bad++; $display("FAIL rs_zero_preset got %0d/%h want 3/00", state, bcd_out); end
   endtask

   task automatic test_borrow();
      clear = 1'b1; cyc(); clear = 1'b0;
      load_val = 8'h20; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; cyc(); tick = 1'b0;
      cmp++; if (bcd_out !== 8'h19) begin bad++; $display("FAIL br_20 got %h want 19", bcd_out); end
      pause = 1'b1; cyc(); pause = 1'b0;
      load_val = 8'h10; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (bcd_out !== 8'h10 || state !== 2'd2) begin bad++; $display("FAIL br_pload got %h/%0d want 10/2", bcd_out, state); end
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; cyc(); tick = 1'b0;
      cmp++; if (bcd_out !== 8'h09) begin bad++; $display("FAIL br_10 got %h want 09", bcd_out); end
      pause = 1'b1; cyc(); pause = 1'b0;
      load_val = 8'h9A; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (bcd_out !== 8'h99) begin bad++; $display("FAIL br_clamp9A got %h want 99", bcd_out); end
      load_val = 8'hF3; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (bcd_out !== 8'h93) begin bad++; $display("FAIL br_clampF3 got %h want 93", bcd_out); end
   endtask

   task automatic test_pause();
      clear = 1'b1; cyc(); clear = 1'b0;
      load_val = 8'h05; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      pause = 1'b1; tick = 1'b1; cyc(); pause = 1'b0;
      cmp++; if (bcd_out !== 8'h05 || state !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL pa_enter got %h/%0d want 05/2", bcd_out, state); end
      cyc(); cyc(); tick = 1'b0;
      cmp++; if (bcd_out !== 8'h05 || state !== 2'd2) begin bad++; $display("FAIL pa_hold got %h/%0d want 05/2", bcd_out, state); end
      start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
      cmp++; if (bcd_out !== 8'h05 || state !== 2'd1) begin bad++; $display("FAIL pa_resume got %h/%0d want 05/1", bcd_out, state); end
      tick = 1'b1; cyc(); tick = 1'b0;
      cmp++; if (bcd_out !== 8'h04) begin bad++; $display("FAIL pa_tick got %h want 04", bcd_out); end
      start = 1'b1; cyc(); start = 1'b0;
      cmp++; if (bcd_out !== 8'h04 || state !== 2'd1) begin bad++; $display("FAIL pa_start_run got %h/%0d want 04/1", bcd_out, state); end
   endtask

   task automatic test_clear();
      clear = 1'b1; cyc(); clear = 1'b0;
      load_val = 8'h07; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      load_val = 8'h33; load = 1'b1; cyc(); load = 1'b0;
      cmp++; if (bcd_out !== 8'h07 || state !== 2'd1) begin bad++; $display("FAIL cl_run_load got %h/%0d want 07/1", bcd_out, state); end
      load_val = 8'h44; clear = 1'b1; load = 1'b1; start = 1'b1; cyc(); zero();
      cmp++; if (bcd_out !== 8'h00 || state !== 2'd0 || done !== 1'b0) begin bad++; $display("FAIL cl_prio got %h/%0d want 00/0", bcd_out, state); end
      rst = 1'b1; clear = 1'b1; cyc(); zero();
      cmp++; if (bcd_out !== 8'h00 || state !== 2'd0) begin bad++; $display("FAIL cl_rst got %h/%0d want 00/0", bcd_out, state); end
   endtask

   task automatic test_reset_final();
      int hits = 0;
      load_val = 8'h02; load = 1'b1; cyc(); load = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      tick = 1'b1; cyc();
      cmp++; if (bcd_out !== 8'h01) begin bad++; $display("FAIL rf_pre got %h want 01", bcd_out); end
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (done !== 1'b0 || state !== 2'd0 || bcd_out !== 8'h00) hits++;
         cyc();
      end
      tick = 1'b0;
      cmp++; if (hits != 0) begin bad++; $display("FAIL rf_after got %0d bad cycles want 0", hits); end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_restart();
      test_borrow();
      test_pause();
      test_clear();
      test_reset_final();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
